// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: sequences one game round at a time (input -> replay -> write
// result -> wait) and tracks completed rounds, ending in WIN at a round
// threshold or LOSE on an external loss.
// Ports:
//   clka, reset           clock, synchronous active-high reset
//   inp, run, wai         input-phase, replay-phase and hold requests
//   lose_sig              loss indication from the compare logic
//   state                 current state encoding (Moore)
//   load_data, read_data  datapath load / read strobes
//   write_data            datapath write-enable (INPUT or IREAD)
//   writeout              one-cycle result write pulse
//   restart, win, lose    status flags decoded from state
//   phase_cnt             cycle index inside INPUT or IREAD
//   round_cnt             completed-round count (saturating)
module seq_game_ctrl #(
  parameter int CNT_W      = 4,
  parameter int INPUT_LEN  = 16,
  parameter int READ_LEN   = 16,
  parameter int ROUND_W    = 9,
  parameter int WIN_ROUNDS = 50,
  parameter int WAIT_CYC   = 5
) (
  input  logic               clka,
  input  logic               reset,
  input  logic               inp,
  input  logic               run,
  input  logic               wai,
  input  logic               lose_sig,
  output logic [2:0]         state,
  output logic               load_data,
  output logic               read_data,
  output logic               write_data,
  output logic               writeout,
  output logic               restart,
  output logic               win,
  output logic               lose,
  output logic [CNT_W-1:0]   phase_cnt,
  output logic [ROUND_W-1:0] round_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_WIN      = 3'b001,
    S_INPUT    = 3'b010,
    S_IREAD    = 3'b011,
    S_WRITEOUT = 3'b100,
    S_WAIT     = 3'b101,
    S_LOSE     = 3'b110,
    S_RESTART  = 3'b111
  } state_t;

  // Wait timer only ever needs to hold WAIT_CYC-1.
  localparam int WT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  localparam logic [CNT_W-1:0]   IN_LAST   = CNT_W'(INPUT_LEN - 1);
  localparam logic [CNT_W-1:0]   RD_LAST   = CNT_W'(READ_LEN - 1);
  localparam logic [WT_W-1:0]    WAIT_LAST = WT_W'(WAIT_CYC - 1);
  localparam logic [ROUND_W-1:0] WIN_TH    = ROUND_W'(WIN_ROUNDS);

  state_t             cur_state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   phase_nxt;
  logic [ROUND_W-1:0] round_nxt;
  logic [ROUND_W-1:0] round_inc;
  logic [WT_W-1:0]    wait_tmr;
  logic [WT_W-1:0]    wait_nxt;
  logic               lose_pend;
  logic               pend_nxt;
  logic               lose_any;

  // Round counter sticks at all-ones rather than wrapping back below the
  // win threshold.
  assign round_inc = (round_cnt == {ROUND_W{1'b1}}) ? round_cnt
                                                    : round_cnt + 1'b1;
  assign lose_any  = lose_sig | lose_pend;

  always_ff @(posedge clka) begin
    if (reset) begin
      cur_state <= S_RESTART;
      phase_cnt <= '0;
      round_cnt <= '0;
      wait_tmr  <= '0;
      lose_pend <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      phase_cnt <= phase_nxt;
      round_cnt <= round_nxt;
      wait_tmr  <= wait_nxt;
      lose_pend <= pend_nxt;
    end
  end

  // phase_cnt and wait_tmr default to zero, so they are cleared in every
  // state except the one that advances them; entry to a phase therefore
  // always starts from index 0.
  always_comb begin
    nxt_state = cur_state;
    phase_nxt = '0;
    round_nxt = round_cnt;
    wait_nxt  = '0;
    pend_nxt  = lose_pend;
    case (cur_state)
      S_IDLE: begin
        if (inp) begin
          nxt_state = S_INPUT;
        end else if (run) begin
          // A replay request is diverted to WAIT while a loss is known
          // or a hold is requested.
          nxt_state = (lose_any || wai) ? S_WAIT : S_IREAD;
        end else if (wai) begin
          nxt_state = S_WAIT;
        end
      end
      S_INPUT: begin
        pend_nxt = lose_pend | lose_sig;
        if (phase_cnt == IN_LAST) begin
          nxt_state = S_WRITEOUT;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      S_IREAD: begin
        pend_nxt = lose_pend | lose_sig;
        if (phase_cnt == RD_LAST) begin
          nxt_state = S_WRITEOUT;
        end else begin
          phase_nxt = phase_cnt + 1'b1;
        end
      end
      S_WRITEOUT: begin
        pend_nxt  = lose_pend | lose_sig;
        round_nxt = round_inc;
        nxt_state = (round_inc >= WIN_TH) ? S_WIN : S_IDLE;
      end
      S_WAIT: begin
        if (lose_any) begin
          nxt_state = S_LOSE;
        end else if (round_cnt >= WIN_TH) begin
          nxt_state = S_WIN;
        end else if (!wai) begin
          if (wait_tmr == WAIT_LAST) begin
            nxt_state = S_IDLE;
          end else begin
            wait_nxt = wait_tmr + 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        nxt_state = cur_state;
      end
      S_RESTART: begin
        nxt_state = inp ? S_INPUT : S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign state      = cur_state;
  assign load_data  = (cur_state == S_INPUT);
  assign read_data  = (cur_state == S_IREAD);
  assign write_data = (cur_state == S_INPUT) || (cur_state == S_IREAD);
  assign writeout   = (cur_state == S_WRITEOUT);
  assign restart    = (cur_state == S_RESTART);
  assign win        = (cur_state == S_WIN);
  assign lose       = (cur_state == S_LOSE);

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Testbench for seq_game_ctrl: directed vector table, hand-written round /
// win / lose sequences, and randomized stimulus against a round-level model.
module tb_seq_game_ctrl;

  localparam int CNT_W      = 4;
  localparam int INPUT_LEN  = 16;
  localparam int READ_LEN   = 3;
  localparam int ROUND_W    = 9;
  localparam int WIN_ROUNDS = 3;
  localparam int WAIT_CYC   = 5;

  localparam int S_IDLE = 0, S_WIN = 1, S_INPUT = 2, S_IREAD = 3;
  localparam int S_WRITEOUT = 4, S_WAIT = 5, S_LOSE = 6, S_RESTART = 7;
  localparam int ROUND_MAX = (1 << ROUND_W) - 1;

  logic               clka = 1'b0;
  logic               reset = 1'b1;
  logic               inp = 1'b0, run = 1'b0, wai = 1'b0, lose_sig = 1'b0;
  logic [2:0]         state;
  logic               load_data, read_data, write_data, writeout;
  logic               restart, win, lose;
  logic [CNT_W-1:0]   phase_cnt;
  logic [ROUND_W-1:0] round_cnt;

  int nchk = 0;
  int npass = 0;

  seq_game_ctrl #(
    .CNT_W(CNT_W), .INPUT_LEN(INPUT_LEN), .READ_LEN(READ_LEN),
    .ROUND_W(ROUND_W), .WIN_ROUNDS(WIN_ROUNDS), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clka(clka), .reset(reset), .inp(inp), .run(run), .wai(wai),
    .lose_sig(lose_sig), .state(state), .load_data(load_data),
    .read_data(read_data), .write_data(write_data), .writeout(writeout),
    .restart(restart), .win(win), .lose(lose), .phase_cnt(phase_cnt),
    .round_cnt(round_cnt)
  );

  always #5 clka = ~clka;

  // ---------------- reference model (round-level view) ----------------
  int m_state  = S_RESTART;
  int m_len    = 0;   // length of the phase in progress
  int m_remain = 0;   // cycles of the phase still to run, including current
  int m_round  = 0;
  int m_low    = 0;   // consecutive wai-low cycles seen in WAIT
  bit m_pend   = 0;

  function automatic int m_phase();
    return (m_state == S_INPUT || m_state == S_IREAD) ? (m_len - m_remain) : 0;
  endfunction

  function automatic void m_begin_phase(int st, int len);
    m_state  = st;
    m_len    = len;
    m_remain = len;
  endfunction

  function automatic void model_step(bit r, bit i, bit ru, bit w, bit l);
    if (r) begin
      m_state = S_RESTART; m_round = 0; m_pend = 0; m_low = 0;
      m_len = 0; m_remain = 0;
      return;
    end
    case (m_state)
      S_RESTART: if (i) m_begin_phase(S_INPUT, INPUT_LEN); else m_state = S_IDLE;
      S_IDLE: begin
        if (i) m_begin_phase(S_INPUT, INPUT_LEN);
        else if (ru && (l || m_pend || w)) begin m_state = S_WAIT; m_low = 0; end
        else if (ru) m_begin_phase(S_IREAD, READ_LEN);
        else if (w) begin m_state = S_WAIT; m_low = 0; end
      end
      S_INPUT, S_IREAD: begin
        if (l) m_pend = 1;
        m_remain--;
        if (m_remain == 0) m_state = S_WRITEOUT;
      end
      S_WRITEOUT: begin
        if (l) m_pend = 1;
        if (m_round < ROUND_MAX) m_round++;
        m_state = (m_round >= WIN_ROUNDS) ? S_WIN : S_IDLE;
      end
      S_WAIT: begin
        if (l || m_pend) m_state = S_LOSE;
        else if (m_round >= WIN_ROUNDS) m_state = S_WIN;
        else if (w) m_low = 0;
        else begin
          m_low++;
          if (m_low == WAIT_CYC) m_state = S_IDLE;
        end
      end
      default: ; // WIN and LOSE hold until reset
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  // {load_data, read_data, write_data, writeout, restart, win, lose}
  function automatic logic [6:0] strobes_of(int s);
    return {s == S_INPUT, s == S_IREAD, (s == S_INPUT) || (s == S_IREAD),
            s == S_WRITEOUT, s == S_RESTART, s == S_WIN, s == S_LOSE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic dut_check(input string tag, input int st, input int ph, input int rd);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"},
        32'({load_data, read_data, write_data, writeout, restart, win, lose}),
        32'(strobes_of(st)));
    chk({tag, ".phase_cnt"}, 32'(phase_cnt), 32'(ph));
    chk({tag, ".round_cnt"}, 32'(round_cnt), 32'(rd));
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge,
  // and always compare against the model.
  task automatic cyc(input bit r, input bit i, input bit ru, input bit w, input bit l);
    @(negedge clka);
    reset = r; inp = i; run = ru; wai = w; lose_sig = l;
    @(posedge clka);
    #1;
    model_step(r, i, ru, w, l);
    dut_check("model", m_state, m_phase(), m_round);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r, i, ru, w, l;
    int st, ph, rd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit i, bit ru, bit w, bit l, int st, int ph, int rd);
    vec_t v;
    v.r = r; v.i = i; v.ru = ru; v.w = w; v.l = l; v.st = st; v.ph = ph; v.rd = rd;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset for two cycles, release with inp low
    add(1,0,0,0,0, S_RESTART, 0, 0);
    add(1,0,0,0,0, S_RESTART, 0, 0);
    add(0,0,0,0,0, S_IDLE,    0, 0);
    // short replay round
    add(0,0,1,0,0, S_IREAD,   0, 0);
    add(0,0,0,0,0, S_IREAD,   1, 0);
    add(0,0,0,0,0, S_IREAD,   2, 0);
    add(0,0,0,0,0, S_WRITEOUT,0, 0);
    add(0,0,0,0,0, S_IDLE,    0, 1);
    // hold for 10 cycles, then a glitch after 3 low cycles
    for (int k = 0; k < 10; k++) add(0,0,0,1,0, S_WAIT, 0, 1);
    for (int k = 0; k < 3; k++)  add(0,0,0,0,0, S_WAIT, 0, 1);
    add(0,0,0,1,0, S_WAIT, 0, 1);
    for (int k = 0; k < 4; k++)  add(0,0,0,0,0, S_WAIT, 0, 1);
    add(0,0,0,0,0, S_IDLE, 0, 1);
    // run together with wai is diverted to WAIT
    add(0,0,1,1,0, S_WAIT, 0, 1);
    for (int k = 0; k < 4; k++)  add(0,0,0,0,0, S_WAIT, 0, 1);
    add(0,0,0,0,0, S_IDLE, 0, 1);
    // run with lose_sig -> WAIT, lose_sig in WAIT -> LOSE (terminal)
    add(0,0,1,0,1, S_WAIT, 0, 1);
    add(0,0,0,0,1, S_LOSE, 0, 1);
    add(0,1,1,0,0, S_LOSE, 0, 1);
    // reset, release with inp -> straight to INPUT, reset mid-INPUT
    add(1,0,0,0,0, S_RESTART, 0, 0);
    add(0,1,0,0,0, S_INPUT,   0, 0);
    add(0,0,0,0,0, S_INPUT,   1, 0);
    add(1,0,0,0,0, S_RESTART, 0, 0);
    add(0,0,0,0,0, S_IDLE,    0, 0);

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].i, tbl[k].ru, tbl[k].w, tbl[k].l);
      dut_check($sformatf("vec%0d", k), tbl[k].st, tbl[k].ph, tbl[k].rd);
    end

    // inp and run together: INPUT wins, full 16-cycle input round
    cyc(0,1,1,0,0);
    dut_check("inp_run", S_INPUT, 0, 0);
    for (int k = 1; k < INPUT_LEN; k++) begin
      cyc(0,0,0,0,0);
      dut_check($sformatf("input_ph%0d", k), S_INPUT, k, 0);
    end
    cyc(0,0,0,0,0); dut_check("input_wo", S_WRITEOUT, 0, 0);
    cyc(0,0,0,0,0); dut_check("input_idle", S_IDLE, 0, 1);

    // lose_sig mid-IREAD: round still completes, next run ends in LOSE
    cyc(0,0,1,0,0); dut_check("lp_ph0", S_IREAD, 0, 1);
    cyc(0,0,0,0,1); dut_check("lp_ph1", S_IREAD, 1, 1);
    cyc(0,0,0,0,0); dut_check("lp_ph2", S_IREAD, 2, 1);
    cyc(0,0,0,0,0); dut_check("lp_wo",  S_WRITEOUT, 0, 1);
    cyc(0,0,0,0,0); dut_check("lp_idle", S_IDLE, 0, 2);
    cyc(0,0,1,0,0); dut_check("lp_wait", S_WAIT, 0, 2);
    cyc(0,0,0,0,0); dut_check("lp_lose", S_LOSE, 0, 2);

    // three rounds -> WIN straight from the third WRITEOUT
    cyc(1,0,0,0,0); dut_check("w_rst", S_RESTART, 0, 0);
    cyc(0,0,0,0,0); dut_check("w_idle", S_IDLE, 0, 0);
    for (int rnd = 0; rnd < WIN_ROUNDS; rnd++) begin
      cyc(0,1,0,0,0);
      for (int k = 1; k < INPUT_LEN; k++) cyc(0,0,0,0,0);
      dut_check($sformatf("w_r%0d_last", rnd), S_INPUT, INPUT_LEN-1, rnd);
      cyc(0,0,0,0,0);
      dut_check($sformatf("w_r%0d_wo", rnd), S_WRITEOUT, 0, rnd);
      cyc(0,0,0,0,0);
      if (rnd == WIN_ROUNDS-1) dut_check("w_win", S_WIN, 0, rnd+1);
      else dut_check($sformatf("w_r%0d_idle", rnd), S_IDLE, 0, rnd+1);
    end
    cyc(0,1,0,0,0); dut_check("win_inp", S_WIN, 0, WIN_ROUNDS);
    cyc(0,0,1,1,1); dut_check("win_run", S_WIN, 0, WIN_ROUNDS);
    cyc(1,0,0,0,0); dut_check("win_rst", S_RESTART, 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0,49) == 0, $urandom_range(0,7) == 0,
          $urandom_range(0,5) == 0, $urandom_range(0,3) == 0,
          $urandom_range(0,19) == 0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
